// File: rtl/fir_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_seq_pkg                                                  |
// | Description : Shared types and constants for the FIR MAC sequencer: state  |
// |               enum, default widths, DSP feedback codes and a modular       |
// |               subtraction helper for the circular delay line.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    FLUSH = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int DEF_NTAPS = 4;
  localparam int DEF_A_W   = 20;
  localparam int DEF_B_W   = 18;
  localparam int DEF_Z_W   = 38;
  localparam int DEF_OUT_W = 32;

  // DSP feedback_i codes: keep accumulating, or reload the accumulator
  localparam logic [2:0] FB_ACC  = 3'd0;
  localparam logic [2:0] FB_LOAD = 3'd1;

  // (a - b) mod n for a, b already in [0, n); n need not be a power of two
  function automatic int unsigned mod_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned n);
    return (a >= b) ? (a - b) : (a + n - b);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_delay_line                                               |
// | Description : NTAPS x B_W circular sample buffer. Each write stores at the |
// |               write pointer and advances it modulo NTAPS. The read port    |
// |               returns the sample tap_i positions older than head_i.        |
// |               Reset clears the pointer and every entry.                    |
// | Ports       : clock_i, s_reset_n (sync, active low)                        |
// |               wr_en_i/wr_data_i  - sample write                            |
// |               wp_o               - current write pointer                   |
// |               head_i/tap_i       - read base and age offset                |
// |               rd_data_o          - selected sample (combinational)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_delay_line
  import fir_seq_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int B_W   = DEF_B_W,
  localparam int PW   = $clog2(NTAPS)
) (
  input  logic          clock_i,
  input  logic          s_reset_n,
  input  logic          wr_en_i,
  input  logic [B_W-1:0] wr_data_i,
  output logic [PW-1:0] wp_o,
  input  logic [PW-1:0] head_i,
  input  logic [PW-1:0] tap_i,
  output logic [B_W-1:0] rd_data_o
);

  logic [B_W-1:0] mem_q [NTAPS];
  logic [PW-1:0]  wp_q;
  logic [PW-1:0]  wp_d;
  logic [PW-1:0]  w_rd_addr;

  assign wp_d = (wp_q == PW'(NTAPS - 1)) ? '0 : wp_q + PW'(1);

  // Older samples sit at lower addresses, wrapping below zero to the top
  assign w_rd_addr = PW'(mod_sub(32'(head_i), 32'(tap_i), NTAPS));
  assign rd_data_o = mem_q[w_rd_addr];
  assign wp_o      = wp_q;

  always_ff @(posedge clock_i) begin
    if (!s_reset_n) begin
      wp_q <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wp_q] <= wr_data_i;
      wp_q        <= wp_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fir_mac_sequencer                                            |
// | Description : Drives one DSP block in accumulate mode as an NTAPS-tap FIR. |
// |               Per accepted sample: NTAPS MAC cycles, one FLUSH cycle that  |
// |               captures z_i, then the result is held on a valid/ready port. |
// | Ports       : clock_i, s_reset_n (sync, active low)                        |
// |               in_valid_i/in_data_i/in_ready_o        - sample input        |
// |               coeff_we_i/coeff_addr_i/coeff_data_i   - coefficient load    |
// |               a_o, b_o, acc_fir_o, feedback_o,                             |
// |               load_acc_o, subtract_o, z_i            - DSP interface       |
// |               out_valid_o/out_data_o/out_ready_i     - result output       |
// | Options     : FIR_SEQ_SATURATE_EN - clamp z_i to the signed OUT_W range    |
// |               instead of truncating.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fir_mac_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NTAPS = DEF_NTAPS,
  parameter int A_W   = DEF_A_W,
  parameter int B_W   = DEF_B_W,
  parameter int Z_W   = DEF_Z_W,
  parameter int OUT_W = DEF_OUT_W,
  localparam int PW   = $clog2(NTAPS)
) (
  input  logic             clock_i,
  input  logic             s_reset_n,
  input  logic             in_valid_i,
  input  logic [B_W-1:0]   in_data_i,
  output logic             in_ready_o,
  input  logic             coeff_we_i,
  input  logic [PW-1:0]    coeff_addr_i,
  input  logic [A_W-1:0]   coeff_data_i,
  output logic [A_W-1:0]   a_o,
  output logic [B_W-1:0]   b_o,
  output logic [5:0]       acc_fir_o,
  output logic [2:0]       feedback_o,
  output logic             load_acc_o,
  output logic             subtract_o,
  input  logic [Z_W-1:0]   z_i,
  output logic             out_valid_o,
  output logic [OUT_W-1:0] out_data_o,
  input  logic             out_ready_i
);

  state_e           state_q, state_d;
  logic [PW-1:0]    tap_q, tap_d;
  logic [PW-1:0]    head_q, head_d;
  logic [A_W-1:0]   coeff_q [NTAPS];
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] w_z_res;
  logic [PW-1:0]    w_wp;
  logic [B_W-1:0]   w_buf_rd;
  logic             w_buf_we;
  logic             w_coeff_wr;

  assign acc_fir_o   = '0;
  assign load_acc_o  = 1'b1;
  assign subtract_o  = 1'b0;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Out-of-range addresses (non power-of-two NTAPS) are dropped
  assign w_coeff_wr = (state_q == IDLE) && coeff_we_i && (32'(coeff_addr_i) < NTAPS);

  fir_delay_line #(
    .NTAPS (NTAPS),
    .B_W   (B_W)
  ) u_delay_line (
    .clock_i   (clock_i),
    .s_reset_n (s_reset_n),
    .wr_en_i   (w_buf_we),
    .wr_data_i (in_data_i),
    .wp_o      (w_wp),
    .head_i    (head_q),
    .tap_i     (tap_q),
    .rd_data_o (w_buf_rd)
  );

`ifdef FIR_SEQ_SATURATE_EN
  // In range only when every bit from the OUT_W sign bit upward agrees
  logic [Z_W-OUT_W:0] w_z_hi;
  assign w_z_hi = z_i[Z_W-1:OUT_W-1];

  always_comb begin
    w_z_res = z_i[OUT_W-1:0];
    if (!((&w_z_hi) || !(|w_z_hi))) begin
      w_z_res = z_i[Z_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic w_unused_z_hi;
  assign w_unused_z_hi = ^z_i[Z_W-1:OUT_W];
  assign w_z_res       = z_i[OUT_W-1:0];
`endif

  always_ff @(posedge clock_i) begin
    if (!s_reset_n) begin
      state_q     <= IDLE;
      tap_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        coeff_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      // Lands on the same edge as a sample accept, so the MAC run sees it
      if (w_coeff_wr) begin
        coeff_q[coeff_addr_i] <= coeff_data_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    head_d      = head_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    in_ready_o  = 1'b0;
    w_buf_we    = 1'b0;
    a_o         = '0;
    b_o         = '0;
    feedback_o  = FB_ACC;

    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          w_buf_we = 1'b1;
          head_d   = w_wp;
          tap_d    = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        a_o        = coeff_q[tap_q];
        b_o        = w_buf_rd;
        feedback_o = FB_ACC;
        if (tap_q == PW'(NTAPS - 1)) begin
          state_d = FLUSH;
        end else begin
          tap_d = tap_q + PW'(1);
        end
      end
      FLUSH: begin
        // Zero operands with a reload leave the accumulator cleared for the next sample
        feedback_o  = FB_LOAD;
        out_data_d  = w_z_res;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fir_mac_sequencer                                         |
// | Description : Self-checking bench for fir_mac_sequencer with a behavioural |
// |               accumulate-mode DSP stand-in and a direct-form FIR model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fir_mac_sequencer;

  localparam int NTAPS = 4;
  localparam int A_W   = 20;
  localparam int B_W   = 18;
  localparam int Z_W   = 38;
  localparam int OUT_W = 32;
  localparam int PW    = 2;

  logic             clock_i = 1'b0;
  logic             s_reset_n = 1'b0;
  logic             in_valid_i = 1'b0;
  logic [B_W-1:0]   in_data_i = '0;
  logic             in_ready_o;
  logic             coeff_we_i = 1'b0;
  logic [PW-1:0]    coeff_addr_i = '0;
  logic [A_W-1:0]   coeff_data_i = '0;
  logic [A_W-1:0]   a_o;
  logic [B_W-1:0]   b_o;
  logic [5:0]       acc_fir_o;
  logic [2:0]       feedback_o;
  logic             load_acc_o;
  logic             subtract_o;
  logic [Z_W-1:0]   z_i;
  logic             out_valid_o;
  logic [OUT_W-1:0] out_data_o;
  logic             out_ready_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock_i = ~clock_i;

  fir_mac_sequencer #(
    .NTAPS (NTAPS), .A_W (A_W), .B_W (B_W), .Z_W (Z_W), .OUT_W (OUT_W)
  ) dut (
    .clock_i      (clock_i),
    .s_reset_n    (s_reset_n),
    .in_valid_i   (in_valid_i),
    .in_data_i    (in_data_i),
    .in_ready_o   (in_ready_o),
    .coeff_we_i   (coeff_we_i),
    .coeff_addr_i (coeff_addr_i),
    .coeff_data_i (coeff_data_i),
    .a_o          (a_o),
    .b_o          (b_o),
    .acc_fir_o    (acc_fir_o),
    .feedback_o   (feedback_o),
    .load_acc_o   (load_acc_o),
    .subtract_o   (subtract_o),
    .z_i          (z_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_ready_i  (out_ready_i)
  );

  // Accumulate-mode DSP stand-in: registered accumulator, z = round-shift of it
  longint dsp_acc;
  longint dsp_prod;
  longint dsp_rnd;
  longint dsp_z;
  int     dsp_shift = 10;

  always_comb begin
    dsp_prod = longint'($signed(a_o)) * longint'($signed(b_o));
    dsp_rnd  = (dsp_shift > 0) ? (64'sd1 <<< (dsp_shift - 1)) : 64'sd0;
    dsp_z    = (dsp_acc + dsp_rnd) >>> dsp_shift;
  end
  assign z_i = dsp_z[Z_W-1:0];

  always @(posedge clock_i) begin
    if (!s_reset_n)              dsp_acc <= 0;
    else if (feedback_o == 3'd1) dsp_acc <= dsp_prod;
    else if (feedback_o == 3'd0) dsp_acc <= dsp_acc + dsp_prod;
  end

  // Reference: y[n] = sum_k c[k] * x[n-k], samples before reset count as zero
  longint hist[$];
  longint ref_coeff[NTAPS];

  function automatic logic [31:0] ref_out();
    longint sum = 0;
    longint z;
    int     n = hist.size() - 1;
    for (int k = 0; k < NTAPS; k++) begin
      if (n - k >= 0) sum += ref_coeff[k] * hist[n - k];
    end
    if (dsp_shift > 0) sum += (64'sd1 <<< (dsp_shift - 1));
    z = sum >>> dsp_shift;
    z = (z <<< (64 - Z_W)) >>> (64 - Z_W);
`ifdef FIR_SEQ_SATURATE_EN
    if (z > 64'sh7FFFFFFF)          return 32'h7FFFFFFF;
    if (z < -64'sh80000000)         return 32'h80000000;
`endif
    return z[31:0];
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic write_coeff(input int addr, input logic signed [A_W-1:0] val);
    coeff_we_i   = 1'b1;
    coeff_addr_i = PW'(addr);
    coeff_data_i = val;
    tick();
    coeff_we_i = 1'b0;
    ref_coeff[addr] = longint'(val);
  endtask

  // One sample through the pipe. hold: cycles of out_ready_i low after valid.
  // wr_with: coeff[0]=7 written together with the accept. wr_busy: same write during MAC.
  task automatic run_sample(input string tag, input logic signed [B_W-1:0] s,
                            input int hold, input bit wr_with, input bit wr_busy);
    int          waitc = 0;
    int          lat = 0;
    logic [31:0] exp;
    out_ready_i = (hold == 0);
    while (!in_ready_o && waitc < 50) begin
      tick();
      waitc++;
    end
    check_val({tag, "_in_ready"}, in_ready_o, 1);
    in_valid_i = 1'b1;
    in_data_i  = s;
    if (wr_with) begin
      coeff_we_i   = 1'b1;
      coeff_addr_i = '0;
      coeff_data_i = 20'h00007;
    end
    tick();
    in_valid_i = 1'b0;
    coeff_we_i = 1'b0;
    if (wr_with) ref_coeff[0] = 7;
    hist.push_back(longint'(s));
    exp = ref_out();
    check_val({tag, "_busy_ready"}, in_ready_o, 0);
    if (wr_busy) begin
      coeff_we_i   = 1'b1;
      coeff_addr_i = '0;
      coeff_data_i = 20'h00007;
    end
    while (!out_valid_o && lat < 50) begin
      tick();
      coeff_we_i = 1'b0;
      lat++;
    end
    coeff_we_i = 1'b0;
    check_val({tag, "_latency"}, lat, NTAPS + 1);
    check_val({tag, "_out"}, out_data_o, exp);
    if (hold > 0) begin
      repeat (hold) tick();
      check_val({tag, "_hold_valid"}, out_valid_o, 1);
      check_val({tag, "_hold_data"}, out_data_o, exp);
      check_val({tag, "_hold_ready"}, in_ready_o, 0);
      out_ready_i = 1'b1;
    end
    tick();
    check_val({tag, "_rel_valid"}, out_valid_o, 0);
    check_val({tag, "_rel_ready"}, in_ready_o, 1);
  endtask

  task automatic load_std_coeffs();
    write_coeff(0, 20'h0000B);
    write_coeff(1, 20'h0000E);
    write_coeff(2, 20'h0000E);
    write_coeff(3, 20'h0000F);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NTAPS; k++) ref_coeff[k] = 0;
    s_reset_n = 1'b0;
    repeat (3) tick();
    s_reset_n = 1'b1;
    check_val("rst_in_ready", in_ready_o, 1);
    check_val("rst_out_valid", out_valid_o, 0);
    check_val("rst_out_data", out_data_o, 0);
    check_val("rst_a", a_o, 0);
    check_val("rst_b", b_o, 0);
    check_val("rst_feedback", feedback_o, 0);
    check_val("load_acc", load_acc_o, 1);
    check_val("subtract", subtract_o, 0);
    check_val("acc_fir", acc_fir_o, 0);

    load_std_coeffs();

    run_sample("imp0", 18'h00400, 0, 0, 0);
    check_val("imp0_plan", out_data_o, 32'h0000000B);
    run_sample("imp1", 18'h00000, 0, 0, 0);
    check_val("imp1_plan", out_data_o, 32'h0000000E);
    run_sample("imp2", 18'h00000, 0, 0, 0);
    run_sample("imp3", 18'h00000, 0, 0, 0);
    check_val("imp3_plan", out_data_o, 32'h0000000F);

    for (int i = 0; i < 6; i++) run_sample("steady", 18'h00400, 0, 0, 0);
    check_val("steady_plan", out_data_o, 32'h00000036);

    for (int i = 0; i < 8; i++) run_sample("wrap_z", 18'h00000, 0, 0, 0);
    run_sample("wrap8", 18'h00800, 0, 0, 0);
    check_val("wrap8_plan", out_data_o, 32'h00000016);

    run_sample("bp", 18'h00400, 10, 0, 0);
    run_sample("bp_next", 18'h00000, 0, 0, 0);

    for (int i = 0; i < 3; i++) run_sample("flushz", 18'h00000, 0, 0, 0);
    run_sample("busy_wr", 18'h00200, 0, 0, 1);
    run_sample("idle_wr", 18'h00400, 0, 1, 0);

    // Full-scale random phase with no shift so z overflows OUT_W
    dsp_shift = 0;
    for (int k = 0; k < NTAPS; k++) write_coeff(k, A_W'($urandom));
    for (int i = 0; i < 24; i++) begin
      run_sample("rand", B_W'($urandom), int'($urandom_range(0, 3)), 0, 0);
    end

    // Mid-operation reset during MAC tap 2
    dsp_shift = 10;
    load_std_coeffs();
    run_sample("pre_rst", 18'h01234, 0, 0, 0);
    in_valid_i = 1'b1;
    in_data_i  = 18'h02345;
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    s_reset_n = 1'b0;
    tick();
    s_reset_n = 1'b1;
    hist.delete();
    for (int k = 0; k < NTAPS; k++) ref_coeff[k] = 0;
    check_val("mrst_in_ready", in_ready_o, 1);
    check_val("mrst_out_valid", out_valid_o, 0);
    check_val("mrst_a", a_o, 0);
    check_val("mrst_feedback", feedback_o, 0);
    run_sample("mrst_imp", 18'h00400, 0, 0, 0);
    check_val("mrst_imp_plan", out_data_o, 0);
    load_std_coeffs();
    for (int i = 0; i < 3; i++) run_sample("mrst_tail", 18'h00000, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
